// File: rtl/shift_arb.sv
// Two-requester round-robin scheduler feeding a tagged shift delay line.
// Each stage carries data plus valid/source tags so qout reports the word's origin.
module shift_arb #(
   parameter int BIT_WIDTH = 8,
   parameter int NUM_REG   = 4,
   parameter int LEN_W     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic [LEN_W-1:0]     len0,
   input  logic [BIT_WIDTH-1:0] din0,
   output logic                 gnt0,
   output logic                 take0,
   input  logic                 req1,
   input  logic [LEN_W-1:0]     len1,
   input  logic [BIT_WIDTH-1:0] din1,
   output logic                 gnt1,
   output logic                 take1,
   input  logic                 hold,
   input  logic                 flush,
   output logic [BIT_WIDTH-1:0] qout,
   output logic                 qout_vld,
   output logic                 qout_src,
   output logic                 busy
);

   // Handshake: a requester holds reqX high until gntX; while gntX is high,
   // takeX marks each cycle in which dinX is consumed into stage 0.
   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t               state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 rr_q, rr_d;
   logic [LEN_W-1:0]     cnt_q, cnt_d;
   logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                 pick;

   logic [BIT_WIDTH-1:0] data_q [NUM_REG];
   logic [NUM_REG-1:0]   vld_q, src_q;
   logic [BIT_WIDTH-1:0] qout_q;
   logic                 qout_vld_q, qout_src_q;
   logic                 take_any;
   logic [BIT_WIDTH-1:0] stage0_data;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      pick    = 1'b0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (!hold) begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  // rr only matters when both ask at once
                  pick    = (req0 && req1) ? rr_q : req1;
                  owner_d = pick;
                  cnt_d   = pick ? len1 : len0;
                  rr_d    = !pick;
                  state_d = STREAM;
               end
            end
            STREAM: begin
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - LEN_W'(1);
            end
            default: state_d = IDLE;
         endcase
      end
      gnt0_d = (state_d == STREAM) && !owner_d;
      gnt1_d = (state_d == STREAM) && owner_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
      end
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign take0       = gnt0_q && !hold && !flush;
   assign take1       = gnt1_q && !hold && !flush;
   assign take_any    = take0 || take1;
   assign stage0_data = take0 ? din0 : (take1 ? din1 : '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REG; i++) data_q[i] <= '0;
         vld_q      <= '0;
         src_q      <= '0;
         qout_q     <= '0;
         qout_vld_q <= 1'b0;
         qout_src_q <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < NUM_REG; i++) data_q[i] <= '0;
         vld_q      <= '0;
         src_q      <= '0;
         qout_q     <= '0;
         qout_vld_q <= 1'b0;
         qout_src_q <= 1'b0;
      end else if (!hold) begin
         data_q[0] <= stage0_data;
         for (int i = 1; i < NUM_REG; i++) data_q[i] <= data_q[i-1];
         vld_q      <= {vld_q[NUM_REG-2:0], take_any};
         src_q      <= {src_q[NUM_REG-2:0], take1};
         qout_q     <= data_q[NUM_REG-1];
         qout_vld_q <= vld_q[NUM_REG-1];
         qout_src_q <= src_q[NUM_REG-1];
      end
   end

   assign qout     = qout_q;
   assign qout_vld = qout_vld_q;
   assign qout_src = qout_src_q;
   assign busy     = (state_q != IDLE) || qout_vld_q || (|vld_q);

endmodule

// File: tb/tb_shift_arb.sv
// Directed bench for shift_arb: per-cycle grant/take/latency checks plus an
// in-order scoreboard of {src,data} for every word that leaves qout.
module tb_shift_arb;

   localparam int W  = 8;
   localparam int LW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, hold, flush;
   logic [LW-1:0] len0, len1;
   logic [W-1:0]  din0, din1;
   logic          gnt0, gnt1, take0, take1;
   logic [W-1:0]  qout;
   logic          qout_vld, qout_src, busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int idx0 = 0;
   int idx1 = 0;
   logic adv_q = 1'b0;

   logic [W:0]   exp_q[$];
   logic [W-1:0] feed0 [0:31];
   logic [W-1:0] feed1 [0:31];

   shift_arb #(.BIT_WIDTH(W), .NUM_REG(4), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .len0(len0), .din0(din0), .gnt0(gnt0), .take0(take0),
      .req1(req1), .len1(len1), .din1(din1), .gnt1(gnt1), .take1(take1),
      .hold(hold), .flush(flush),
      .qout(qout), .qout_vld(qout_vld), .qout_src(qout_src), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // producers: present the next table word, advance on each take
   assign din0 = feed0[idx0];
   assign din1 = feed1[idx1];
   always @(posedge clk) begin
      if (take0) idx0 <= idx0 + 1;
      if (take1) idx1 <= idx1 + 1;
      adv_q <= !hold;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // scoreboard monitor: one pop per freshly shifted-in valid qout word
   always @(negedge clk) begin
      if (rst && qout_vld && adv_q) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got src=%0d data=0x%0h expected no word at cycle %0d",
                     qout_src, qout, cyc);
         end else begin
            chk("sb_word", {23'd0, qout_src, qout}, {23'd0, exp_q.pop_front()});
         end
      end
   end

   // driver tasks
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic src, input logic [W-1:0] d);
      exp_q.push_back({src, d});
   endtask

   task automatic wait_gnt(input bit sel, output int at);
      int k = 0;
      while (((sel ? gnt1 : gnt0) !== 1'b1) && k < 30) begin
         next_cyc();
         k++;
      end
      at = cyc;
      chk(sel ? "gnt1_wait" : "gnt0_wait", {31'd0, sel ? gnt1 : gnt0}, 32'd1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 60) begin
         next_cyc();
         k++;
      end
      chk("idle_wait", {31'd0, busy}, 32'd0);
      repeat (2) next_cyc();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) next_cyc();
      rst = 1'b1;
      next_cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, u;
      logic [W-1:0] tbl0 [0:14] = '{8'h11, 8'h22, 8'h33, 8'h41, 8'h42, 8'h81, 8'h82, 8'h83,
                                    8'h91, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      logic [W-1:0] tbl1 [0:7]  = '{8'h51, 8'h52, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA1, 8'h71};
      for (int i = 0; i < 32; i++) begin
         feed0[i] = 8'hEE;
         feed1[i] = 8'hDD;
      end
      for (int i = 0; i < 15; i++) feed0[i] = tbl0[i];
      feed0[15] = 8'h07;
      feed0[16] = 8'h08;
      for (int i = 0; i < 8; i++) feed1[i] = tbl1[i];

      rst = 1'b0; req0 = 0; req1 = 0; len0 = '0; len1 = '0; hold = 0; flush = 0;
      repeat (3) next_cyc();
      @(negedge clk);
      chk("rst_gnt0", {31'd0, gnt0}, 0);
      chk("rst_gnt1", {31'd0, gnt1}, 0);
      chk("rst_take", {30'd0, take0, take1}, 0);
      chk("rst_qout", {22'd0, qout_src, qout_vld, qout}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      next_cyc();
      rst = 1'b1;
      next_cyc();

      // single burst, len0=2
      push_exp(0, 8'h11); push_exp(0, 8'h22); push_exp(0, 8'h33);
      req0 = 1; len0 = 3'd2;
      wait_gnt(0, t);
      req0 = 0;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         chk("t1_gnt0", {31'd0, gnt0}, {31'd0, c < 3});
         chk("t1_take0", {31'd0, take0}, {31'd0, c < 3});
         if (c >= 5 && c <= 7) begin
            chk("t1_qvld", {31'd0, qout_vld}, 1);
            chk("t1_qsrc", {31'd0, qout_src}, 0);
            chk("t1_qout", {24'd0, qout}, {24'd0, 8'h11 * 8'(c - 4)});
         end
         if (c == 8) begin
            chk("t1_qvld_end", {31'd0, qout_vld}, 0);
            chk("t1_busy_end", {31'd0, busy}, 0);
         end
         next_cyc();
      end
      wait_idle();

      // contention, len=0 each, two rounds from rr=0
      do_reset();
      for (int r = 0; r < 2; r++) begin
         push_exp(0, feed0[3 + r]); push_exp(1, feed1[r]);
         req0 = 1; req1 = 1; len0 = 0; len1 = 0;
         wait_gnt(0, t);
         req0 = 0;
         wait_gnt(1, u);
         req1 = 0;
         chk("t2_bubble", u - t, 2);
      end
      wait_idle();

      // hold for two cycles after the second take, len1=3
      push_exp(1, 8'h61); push_exp(1, 8'h62); push_exp(1, 8'h63); push_exp(1, 8'h64);
      req1 = 1; len1 = 3'd3;
      wait_gnt(1, t);
      req1 = 0;
      for (int c = 0; c <= 10; c++) begin
         hold = (c == 2 || c == 3);
         @(negedge clk);
         chk("t3_take1", {31'd0, take1}, {31'd0, c <= 1 || c == 4 || c == 5});
         chk("t3_gnt1", {31'd0, gnt1}, {31'd0, c <= 5});
         chk("t3_qvld", {31'd0, qout_vld}, {31'd0, c >= 7});
         if (c >= 7) chk("t3_qout", {24'd0, qout}, {24'd0, 8'h61 + 8'(c - 7)});
         next_cyc();
      end
      hold = 0;
      wait_idle();

      // flush after three takes of an eight-word burst
      req0 = 1; len0 = 3'd7;
      wait_gnt(0, t);
      req0 = 0;
      for (int c = 0; c <= 8; c++) begin
         flush = (c == 3);
         @(negedge clk);
         chk("t4_take0", {31'd0, take0}, {31'd0, c <= 2});
         chk("t4_gnt0", {31'd0, gnt0}, {31'd0, c <= 3});
         if (c >= 4) begin
            chk("t4_qvld", {31'd0, qout_vld}, 0);
            chk("t4_busy", {31'd0, busy}, 0);
         end
         next_cyc();
      end
      flush = 0;

      // rr survives flush: last owner was 0, so requester 1 wins
      push_exp(1, 8'hA1); push_exp(0, 8'h91);
      req0 = 1; req1 = 1; len0 = 0; len1 = 0;
      wait_gnt(1, t);
      req1 = 0;
      wait_gnt(0, u);
      req0 = 0;
      chk("t4_rr_order", u - t, 2);
      wait_idle();

      // asynchronous reset mid-stream, then req1 alone
      req1 = 1; len1 = 3'd1;
      wait_gnt(1, t);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_gnt1", {31'd0, gnt1}, 0);
      chk("t5_async_take1", {31'd0, take1}, 0);
      chk("t5_async_busy", {31'd0, busy}, 0);
      len1 = 0;
      @(negedge clk);
      #1;
      push_exp(1, 8'h71);
      rst = 1'b1;
      wait_gnt(1, u);
      req1 = 0;
      @(negedge clk);
      chk("t5_gnt0_low", {31'd0, gnt0}, 0);
      next_cyc();
      wait_idle();

      // maximum length burst, len0=7
      for (int i = 1; i <= 8; i++) push_exp(0, 8'(i));
      req0 = 1; len0 = 3'd7;
      wait_gnt(0, t);
      req0 = 0;
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         chk("t6_take0", {31'd0, take0}, {31'd0, c <= 7});
         chk("t6_qvld", {31'd0, qout_vld}, {31'd0, c >= 5 && c <= 12});
         if (c >= 5 && c <= 12) chk("t6_qout", {24'd0, qout}, {24'd0, 8'(c - 4)});
         if (c == 13) chk("t6_busy", {31'd0, busy}, 0);
         next_cyc();
      end
      wait_idle();

      chk("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
